// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_ctrl_pkg;

   // Job phases of the sequencer, in the order one job walks through them.
   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      SWITCH,
      STREAM,
      DRAIN,
      DONE
   } seq_state_t;

   // Buffer read latency: an enable at cycle t presents data at cycle t+1.
   localparam int READ_LAT = 1;

   // Drain covers the valid skew tail plus n south hops through the array.
   function automatic int drain_len(input int n);
      return 2 * n;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Single-bit shift register used to skew control strobes across rows/columns.
module skew_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr;

   generate
      if (DEPTH == 1) begin : g_single
         // Single stage: register the strobe once.
         // NOTE: every stage is reset, not just the output; a stale bit left in
         // the middle of the line would otherwise emerge as a phantom strobe
         // after reset is released.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) sr <= '0;
            else     sr <= din;
         end
      end else begin : g_multi
         // Multi stage: shift the strobe one position per cycle.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) sr <= '0;
            else     sr <= {sr[DEPTH-2:0], din};
         end
      end
   endgenerate

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the N x N weight-stationary systolic array: weight load,
// switch, input streaming and drain, issuing buffer reads and skewed strobes.
module systolic_seq_ctrl
   import systolic_ctrl_pkg::*;
#(
   parameter int N      = 2,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_vecs,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [ADDR_W-1:0] x_base,
   output logic              busy,
   output logic              done,
   output logic              w_rd_en,
   output logic [ADDR_W-1:0] w_rd_addr,
   output logic              x_rd_en,
   output logic [ADDR_W-1:0] x_rd_addr,
   output logic [N-1:0]      col_accept_w,
   output logic [N-1:0]      row_switch,
   output logic [N-1:0]      row_valid
);

   localparam int CW        = CNT_W + 1;
   localparam int LOAD_CYC  = 2 * N;
   localparam int DRAIN_CYC = drain_len(N);

   seq_state_t        state;
   logic [CW-1:0]     cnt;
   logic [CNT_W-1:0]  num_vecs_q;
   logic [ADDR_W-1:0] w_base_q;
   logic [ADDR_W-1:0] x_base_q;

   // Look-ahead values: outputs are registered, so each edge loads the value
   // belonging to the cycle that follows it.
   logic [CW-1:0]     cnt_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [ADDR_W-1:0] x_addr_nxt;
   logic              last_vec;

   assign cnt_nxt    = cnt + CW'(1);
   // Bottom weight row is read first, so the address counts down from the base.
   assign w_addr_nxt = w_base_q + ADDR_W'(N - 1) - ADDR_W'(cnt_nxt);
   assign x_addr_nxt = x_base_q + ADDR_W'(cnt_nxt);
   assign last_vec   = (cnt == CW'(num_vecs_q) - CW'(1));

   // Sequencer FSM with registered control outputs.
   // NOTE: all state and outputs use non-blocking assignments so every
   // register samples pre-edge values; blocking here would let later
   // statements see already-updated state within the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         num_vecs_q <= '0;
         w_base_q   <= '0;
         x_base_q   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         w_rd_en    <= 1'b0;
         w_rd_addr  <= '0;
         x_rd_en    <= 1'b0;
         x_rd_addr  <= '0;
         row_switch <= '0;
      end else begin
         done       <= 1'b0;
         w_rd_en    <= 1'b0;
         x_rd_en    <= 1'b0;
         row_switch <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  num_vecs_q <= num_vecs;
                  w_base_q   <= w_base;
                  x_base_q   <= x_base;
                  state      <= LOAD_W;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  w_rd_en    <= 1'b1;
                  w_rd_addr  <= w_base + ADDR_W'(N - 1);
               end
            end
            LOAD_W: begin
               if (cnt == CW'(LOAD_CYC - 1)) begin
                  state      <= SWITCH;
                  cnt        <= '0;
                  row_switch <= '1;
               end else begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt < CW'(N)) begin
                     w_rd_en   <= 1'b1;
                     w_rd_addr <= w_addr_nxt;
                  end
               end
            end
            SWITCH: begin
               cnt <= '0;
               if (num_vecs_q != '0) begin
                  state     <= STREAM;
                  x_rd_en   <= 1'b1;
                  x_rd_addr <= x_base_q;
               end else begin
                  state <= DRAIN;
               end
            end
            STREAM: begin
               if (last_vec) begin
                  state <= DRAIN;
                  cnt   <= '0;
               end else begin
                  cnt       <= cnt_nxt;
                  x_rd_en   <= 1'b1;
                  x_rd_addr <= x_addr_nxt;
               end
            end
            DRAIN: begin
               if (cnt == CW'(DRAIN_CYC - 1)) begin
                  state <= DONE;
                  cnt   <= '0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Column c accepts weights READ_LAT+c cycles after the read was issued.
   for (genvar c = 0; c < N; c++) begin : g_col
      skew_delay_line #(.DEPTH(READ_LAT + c)) u_accept_dl (
         .clk  (clk),
         .rst  (rst),
         .din  (w_rd_en),
         .dout (col_accept_w[c])
      );
   end

   // Row r sees valid READ_LAT+r cycles after the input read was issued.
   for (genvar r = 0; r < N; r++) begin : g_row
      skew_delay_line #(.DEPTH(READ_LAT + r)) u_valid_dl (
         .clk  (clk),
         .rst  (rst),
         .din  (x_rd_en),
         .dout (row_valid[r])
      );
   end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for the N×N weight-stationary systolic PE array.
- Per job, it:
  - reads N weight rows from the weight buffer and shifts them down the columns with skewed accept_w;
  - pulses switch to move inactive weights into the active registers;
  - streams num_vecs input vectors from the unified buffer with per-row skewed valid;
  - drains the array and pulses done.
- Sits between the top-level job control and the array edge drivers. It issues read addresses and enables only; data skew is done in the datapath.

Parameters:
- N, 2: array dimension (rows = columns).
- ADDR_W, 8: buffer address width.
- CNT_W, 8: vector-count width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  job start pulse; accepted only in IDLE
- num_vecs  in  CNT_W  number of input vectors; sampled with start
- w_base  in  ADDR_W  weight-buffer base address; sampled with start
- x_base  in  ADDR_W  input-buffer base address; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- w_rd_en  out  1  weight-buffer read enable; read latency is 1 cycle
- w_rd_addr  out  ADDR_W  weight-buffer read address
- x_rd_en  out  1  input-buffer read enable; read latency is 1 cycle
- x_rd_addr  out  ADDR_W  input-buffer read address
- col_accept_w  out  N  accept_w into the top PE of each column
- row_switch  out  N  switch into the west PE of each row
- row_valid  out  N  valid into the west PE of each row

Behaviour:
- Reset (async, any state): state=IDLE, counters=0, all delay lines=0, every output 0 (addresses 0).
- States: IDLE, LOAD_W, SWITCH, STREAM, DRAIN, DONE. A single counter cnt (CNT_W+1 bits) clears on every state entry.
- IDLE:
  - On start=1, latch num_vecs, w_base and x_base, then go to LOAD_W.
  - start in any other state is ignored and has no effect on latched values.
- LOAD_W (2N cycles, cnt=0..2N-1):
  - For cnt<N: w_rd_en=1 and w_rd_addr = w_base + (N-1-cnt). The bottom row is read first.
  - col_accept_w[c] = w_rd_en delayed by 1+c cycles.
  - Last accept falls at cnt=2N-1. Exit to SWITCH.
- SWITCH (1 cycle):
  - row_switch = all ones.
  - Go to STREAM if latched num_vecs≠0, else go to DRAIN.
- STREAM (num_vecs cycles):
  - x_rd_en=1 and x_rd_addr = x_base + cnt.
  - Exit after cnt = num_vecs-1.
- Valid skew: row_valid[r] = x_rd_en delayed by 1+r cycles. The delay lines keep shifting in every state; they are only cleared by reset.
- DRAIN (2N cycles, fixed): covers the skew tail plus N south hops. No reads are issued.
- DONE (1 cycle): done=1, then return to IDLE. A start on the cycle after DONE is accepted.
- Address arithmetic wraps modulo 2^ADDR_W with no error flag.
- Latency, with start sampled at edge T, N=2, V vectors:
  - LOAD_W: T+1..T+4
  - SWITCH: T+5
  - STREAM: T+6..T+5+V
  - DRAIN: 4 cycles
  - DONE: T+10+V
  - General form: start-to-done = 4N+2+V cycles.
- No simultaneous read: w_rd_en and x_rd_en are never both high.

Decomposition:
- Package systolic_ctrl_pkg:
  - state enum seq_state_t (IDLE, LOAD_W, SWITCH, STREAM, DRAIN, DONE);
  - localparam READ_LAT=1;
  - drain-length function drain_len(N)=2N.
- Sub-module skew_delay_line (parameter DEPTH): a 1-bit shift register with async reset. Instantiate one per column (DEPTH=1+c) and one per row (DEPTH=1+r).

Test Plan:
- Reset values: assert rst mid-cycle with no clock → all outputs 0 immediately. Release rst → busy=0, done=0.
- Full job, N=2, w_base=0x10, x_base=0x40, V=3 → expect:
  - w_rd_addr 0x11, 0x10 at T+1, T+2;
  - col_accept_w[0] high T+2..T+3 and col_accept_w[1] high T+3..T+4;
  - row_switch=2'b11 at T+5;
  - x_rd_addr 0x40..0x42 at T+6..T+8;
  - row_valid[0] high T+7..T+9 and row_valid[1] high T+8..T+10;
  - done=1 at T+13 only.
- start pulsed during STREAM with different num_vecs/bases → ignored: same addresses, same done cycle.
- num_vecs=0 → SWITCH goes directly to DRAIN, x_rd_en never asserted, row_valid stays 0, done at T+10.
- rst asserted during STREAM (cycle T+7) → immediate IDLE with all outputs 0. A new start after release runs a clean full job, with no stale row_valid pulses.
- start asserted on the cycle after done → accepted; second job timing is identical to the first; w_base=0xFF with N=2 reads 0x00 then 0xFF (wrap).
